// File: rtl/parking_sensor_cond.sv
// Barrier-sensor conditioning: 2-flop sync, per-channel debounce, stuck-high
// detection and a RUN/FAULT gate in front of the entry/exit direction FSMs.
module parking_sensor_cond #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a,
    output logic       b,
    output logic       fault,
    output logic [1:0] fault_src
);

    localparam int unsigned   DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [15:0]   ST_LAST  = 16'(STUCK_CYCLES - 1);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] raw;
    logic [1:0] deb;
    logic [1:0] deb_d;
    logic [1:0] stuck_fire;
    logic [1:0] fault_src_d;
    logic       a_d, b_d;

    assign raw = {b_raw, a_raw};

    // Channel 0 = a (outer), channel 1 = b (inner); identical and independent.
    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic          sync1, sync2;
        logic          deb_q, deb_n;
        logic [DW-1:0] deb_cnt_q, deb_cnt_n;
        logic [15:0]   st_cnt_q, st_cnt_n;

        always_comb begin
            deb_n     = deb_q;
            deb_cnt_n = '0;
            if (sync2 != deb_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    deb_n = ~deb_q;
                end else begin
                    deb_cnt_n = deb_cnt_q + 1'b1;
                end
            end

            st_cnt_n = '0;
            if (deb_q) begin
                st_cnt_n = (st_cnt_q == '1) ? st_cnt_q : st_cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                deb_q     <= 1'b0;
                deb_cnt_q <= '0;
                st_cnt_q  <= '0;
            end else begin
                sync1     <= raw[g];
                sync2     <= sync1;
                deb_q     <= deb_n;
                deb_cnt_q <= deb_cnt_n;
                st_cnt_q  <= st_cnt_n;
            end
        end

        assign deb[g]   = deb_q;
        assign deb_d[g] = deb_n;
        // A debounce release on the threshold edge suppresses the fault.
        assign stuck_fire[g] = deb_q & deb_n & (st_cnt_q == ST_LAST);
    end

    // Outputs are computed from next-cycle debounced values so the registered
    // a/b appear on the same edge the debouncer toggles.
    always_comb begin
        state_d     = state_q;
        fault_src_d = fault_src;
        a_d         = 1'b0;
        b_d         = 1'b0;
        case (state_q)
            S_RUN: begin
                if (|stuck_fire) begin
                    state_d     = S_FAULT;
                    fault_src_d = stuck_fire;
                end else begin
                    a_d = deb_d[0];
                    b_d = deb_d[1];
                end
            end
            S_FAULT: begin
                if (deb == 2'b00) begin
                    state_d     = S_RUN;
                    fault_src_d = '0;
                    a_d         = deb_d[0];
                    b_d         = deb_d[1];
                end else begin
                    fault_src_d = fault_src | stuck_fire;
                end
            end
            default: begin
                state_d     = S_RUN;
                fault_src_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RUN;
            fault_src <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
        end else begin
            state_q   <= state_d;
            fault_src <= fault_src_d;
            a         <= a_d;
            b         <= b_d;
        end
    end

    assign fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_parking_sensor_cond.sv
// Directed + randomized bench for parking_sensor_cond against a behavioural
// streak-counting model of the conditioning rules.
module tb_parking_sensor_cond;

    localparam int DEB = 4;
    localparam int STK = 20;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       a_raw = 1'b0;
    logic       b_raw = 1'b0;
    logic       a, b, fault;
    logic [1:0] fault_src;

    int n_vec = 0;
    int n_err = 0;

    parking_sensor_cond #(
        .DEB_CYCLES  (DEB),
        .STUCK_CYCLES(STK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_raw    (a_raw),
        .b_raw    (b_raw),
        .a        (a),
        .b        (b),
        .fault    (fault),
        .fault_src(fault_src)
    );

    always #5 clk = ~clk;

    // Reference model state: raw history, debounced level, run lengths.
    logic [1:0] h0, h1, m_deb, m_src, m_out;
    logic       m_fault;
    int         m_streak[2];
    int         m_high[2];

    task automatic model_reset();
        h0 = 2'b00; h1 = 2'b00; m_deb = 2'b00; m_src = 2'b00; m_out = 2'b00;
        m_fault = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_streak[c] = 0;
            m_high[c]   = 0;
        end
    endtask

    task automatic model_step();
        logic [1:0] seen, nd, reach;
        seen = h1;
        h1   = h0;
        h0   = {b_raw, a_raw};
        for (int c = 0; c < 2; c++) begin
            nd[c] = m_deb[c];
            if (seen[c] !== m_deb[c]) begin
                m_streak[c]++;
                if (m_streak[c] == DEB) begin
                    nd[c] = ~m_deb[c];
                    m_streak[c] = 0;
                end
            end else begin
                m_streak[c] = 0;
            end
            reach[c]  = m_deb[c] && nd[c] && (m_high[c] + 1 == STK);
            m_high[c] = m_deb[c] ? ((m_high[c] < 65535) ? m_high[c] + 1 : 65535) : 0;
        end
        if (!m_fault) begin
            if (reach != 2'b00) begin
                m_fault = 1'b1; m_src = reach; m_out = 2'b00;
            end else begin
                m_out = nd;
            end
        end else if (m_deb == 2'b00) begin
            m_fault = 1'b0; m_src = 2'b00; m_out = nd;
        end else begin
            m_src = m_src | reach; m_out = 2'b00;
        end
        m_deb = nd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step();
        #1;
        chk("model", {27'd0, fault_src, fault, b, a}, {27'd0, m_src, m_fault, m_out[1], m_out[0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [1:0] in_h[55];
    logic [1:0] out_h[55];

    initial begin
        int hi;
        model_reset();

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #2 chk("reset", {27'd0, fault_src, fault, b, a}, 32'd0);
        run(2);
        reset = 1'b1;
        run(3);

        // Clean edge: visible after the 6th edge, and back down likewise.
        a_raw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k == 4) chk("rise_edge4", {31'd0, a}, 32'd0);
            if (k == 5) chk("rise_edge5", {31'd0, a}, 32'd1);
        end
        a_raw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k == 4) chk("fall_edge4", {31'd0, a}, 32'd1);
            if (k == 5) chk("fall_edge5", {31'd0, a}, 32'd0);
        end
        run(3);

        // 3-cycle glitch rejected; 4-cycle pulse passes for exactly 4 cycles.
        hi = 0;
        a_raw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (k == 2) a_raw = 1'b0;
            if (a) hi++;
        end
        chk("glitch3_len", hi, 0);
        hi = 0;
        a_raw = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (k == 3) a_raw = 1'b0;
            if (a) hi++;
        end
        chk("pulse4_len", hi, 4);

        // Stuck b.
        hi = 0;
        b_raw = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (b) hi++;
        end
        chk("stuck_b_len", hi, STK);
        chk("stuck_b_flags", {29'd0, fault_src, fault}, 32'b101);
        b_raw = 1'b0;
        run(10);
        chk("stuck_b_clear", {28'd0, fault_src, fault, b}, 32'd0);

        // Both stuck on the same edge, then staged release.
        a_raw = 1'b1; b_raw = 1'b1;
        run(30);
        chk("both_flags", {29'd0, fault_src, fault}, 32'b111);
        a_raw = 1'b0;
        run(15);
        chk("both_a_released", {29'd0, fault_src, fault}, 32'b111);
        b_raw = 1'b0;
        run(10);
        chk("both_cleared", {29'd0, fault_src, fault}, 32'd0);

        // Reset asserted between edges while in FAULT.
        a_raw = 1'b1;
        run(30);
        chk("pre_reset_fault", {29'd0, fault_src, fault}, 32'b011);
        #2 reset = 1'b0;
        #1 chk("mid_fault_reset", {27'd0, fault_src, fault, b, a}, 32'd0);
        model_reset();
        cycle();
        reset = 1'b1;
        run(5);
        chk("post_reset_edge4", {31'd0, a}, 32'd0);
        cycle();
        chk("post_reset_edge5", {31'd0, a}, 32'd1);
        run(19);
        chk("post_reset_nofault", {30'd0, fault, a}, 32'b01);
        cycle();
        chk("post_reset_fault", {29'd0, fault_src, fault}, 32'b011);
        a_raw = 1'b0;
        run(10);

        // Entry sequence: a, a&b, b, none, 10 cycles each.
        for (int k = 0; k < 55; k++) begin
            in_h[k] = (k < 10) ? 2'b01 : (k < 20) ? 2'b11 : (k < 30) ? 2'b10 : 2'b00;
            {b_raw, a_raw} = in_h[k];
            cycle();
            out_h[k] = {b, a};
        end
        for (int k = 5; k < 55; k++) chk("entry_shift", {30'd0, out_h[k]}, {30'd0, in_h[k-5]});

        // Randomized bursty levels.
        for (int s = 0; s < 60; s++) begin
            {b_raw, a_raw} = 2'($urandom_range(0, 3));
            run($urandom_range(1, 30));
        end
        a_raw = 1'b0; b_raw = 1'b0;
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
